// File: rtl/bram2_tdp_be.sv
// bram2_tdp_be: single-clock true-dual-port block RAM with per-byte write enables.
//
// Features: read-first / write-first same-port read-during-write, optional extra
// output register (read latency 1 or 2) with aligned valid strobes, a one-cycle
// cross-port collision pulse, and a post-reset sweep that writes INIT_VALUE into
// every word.
//
// Ports:
//   CLK, RST             sole clock; synchronous active-high reset
//   ENA/WEA/ADDRA/DIA    port A enable, byte write enables, address, write data
//   DOA, DOA_VALID       port A read data and its one-cycle valid strobe
//   ENB/WEB/ADDRB/DIB    port B equivalents
//   DOB, DOB_VALID       port B read data and valid strobe
//   INIT_BUSY            high in reset or while clearing; all accesses ignored
//   COLLISION            pulse one cycle after a same-address access with a write
module bram2_tdp_be #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned MEMSIZE        = 16,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned NUM_BYTES      = 4,
  parameter int unsigned PIPELINED      = 0,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter logic [NUM_BYTES*BYTE_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             ENA,
  input  logic [NUM_BYTES-1:0]             WEA,
  input  logic [ADDR_WIDTH-1:0]            ADDRA,
  input  logic [NUM_BYTES*BYTE_WIDTH-1:0]  DIA,
  output logic [NUM_BYTES*BYTE_WIDTH-1:0]  DOA,
  output logic                             DOA_VALID,
  input  logic                             ENB,
  input  logic [NUM_BYTES-1:0]             WEB,
  input  logic [ADDR_WIDTH-1:0]            ADDRB,
  input  logic [NUM_BYTES*BYTE_WIDTH-1:0]  DIB,
  output logic [NUM_BYTES*BYTE_WIDTH-1:0]  DOB,
  output logic                             DOB_VALID,
  output logic                             INIT_BUSY,
  output logic                             COLLISION
);

  localparam int unsigned DataWidth = NUM_BYTES * BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEMSIZE - 1);

  typedef enum logic [1:0] {StReset, StClear, StReady} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    clear_we;

  logic [DataWidth-1:0]    mem [MEMSIZE];

  logic                    ready;
  logic                    acc_a, acc_b;
  logic                    in_a, in_b;
  logic [DataWidth-1:0]    old_a, old_b;
  logic [DataWidth-1:0]    merged_a, merged_b;
  logic [DataWidth-1:0]    rd_a, rd_b;

  logic [DataWidth-1:0]    doa1_q, dob1_q;
  logic                    va1_q, vb1_q;
  logic                    coll_q;

  // Sequencer: the first cycle after reset release already clears word 0, so the
  // sweep occupies exactly MEMSIZE cycles of INIT_BUSY.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clear_we = 1'b0;
    case (state_q)
      StReset, StClear: begin
        if (CLEAR_ON_RESET != 0) begin
          clear_we = 1'b1;
          ptr_d    = ptr_q + ADDR_WIDTH'(1);
          state_d  = (ptr_q == LastAddr) ? StReady : StClear;
        end else begin
          state_d = StReady;
        end
      end
      StReady: state_d = StReady;
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StReset;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ready     = (state_q == StReady) && !RST;
  assign INIT_BUSY = (state_q != StReady) || RST;

  assign acc_a = ENA && ready;
  assign acc_b = ENB && ready;
  assign in_a  = 32'(ADDRA) < MEMSIZE;
  assign in_b  = 32'(ADDRB) < MEMSIZE;

  assign old_a = in_a ? mem[ADDRA] : INIT_VALUE;
  assign old_b = in_b ? mem[ADDRB] : INIT_VALUE;

  // Same-port write-first view: own enabled lanes replaced, the rest pre-write.
  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int b = 0; b < int'(NUM_BYTES); b++) begin
      if (WEA[b]) merged_a[b*BYTE_WIDTH +: BYTE_WIDTH] = DIA[b*BYTE_WIDTH +: BYTE_WIDTH];
      if (WEB[b]) merged_b[b*BYTE_WIDTH +: BYTE_WIDTH] = DIB[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign rd_a = (WRITE_MODE != 0 && in_a) ? merged_a : old_a;
  assign rd_b = (WRITE_MODE != 0 && in_b) ? merged_b : old_b;

  // Port B lanes are written after port A lanes so B wins shared lanes.
  always_ff @(posedge CLK) begin
    if (clear_we && !RST) begin
      mem[ptr_q] <= INIT_VALUE;
    end else begin
      for (int b = 0; b < int'(NUM_BYTES); b++) begin
        if (acc_a && in_a && WEA[b]) begin
          mem[ADDRA][b*BYTE_WIDTH +: BYTE_WIDTH] <= DIA[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (acc_b && in_b && WEB[b]) begin
          mem[ADDRB][b*BYTE_WIDTH +: BYTE_WIDTH] <= DIB[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      doa1_q <= '0;
      dob1_q <= '0;
      va1_q  <= 1'b0;
      vb1_q  <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      va1_q  <= acc_a;
      vb1_q  <= acc_b;
      if (acc_a) doa1_q <= rd_a;
      if (acc_b) dob1_q <= rd_b;
      coll_q <= acc_a && acc_b && (ADDRA == ADDRB) && ((|WEA) || (|WEB));
    end
  end

  assign COLLISION = coll_q;

  if (PIPELINED != 0) begin : g_pipe
    logic [DataWidth-1:0] doa2_q, dob2_q;
    logic                 va2_q, vb2_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        doa2_q <= '0;
        dob2_q <= '0;
        va2_q  <= 1'b0;
        vb2_q  <= 1'b0;
      end else begin
        va2_q <= va1_q;
        vb2_q <= vb1_q;
        if (va1_q) doa2_q <= doa1_q;
        if (vb1_q) dob2_q <= dob1_q;
      end
    end

    assign DOA       = doa2_q;
    assign DOB       = dob2_q;
    assign DOA_VALID = va2_q;
    assign DOB_VALID = vb2_q;
  end else begin : g_direct
    assign DOA       = doa1_q;
    assign DOB       = dob1_q;
    assign DOA_VALID = va1_q;
    assign DOB_VALID = vb1_q;
  end

endmodule

// File: doc/bram2_tdp_be.md
Name: bram2_tdp_be

Overview:
- Single-clock true-dual-port block RAM; the parametrised successor to the team's two-port BRAM primitive.
- Adds per-byte write enables, a selectable read-during-write mode, optional output pipelining with aligned valid strobes, a cross-port collision flag, and a post-reset memory-clear sequencer.
- Used as the storage primitive under router buffers and other on-chip tables that need known contents after reset.

Parameters:
- ADDR_WIDTH, 4: address bits per port.
- MEMSIZE, 16: words; must be ≤ 2^ADDR_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane.
- NUM_BYTES, 4: write-enable lanes; DATA_WIDTH = NUM_BYTES*BYTE_WIDTH.
- PIPELINED, 0: 0 = read latency 1; 1 = read latency 2 (extra output register).
- WRITE_MODE, 0: same-port read-during-write; 0 = READ_FIRST (old data), 1 = WRITE_FIRST (merged new data).
- CLEAR_ON_RESET, 1: 1 = sweep INIT_VALUE into every word after reset.
- INIT_VALUE, 0: DATA_WIDTH-bit clear value.

Ports:
- CLK  in  1  sole clock.
- RST  in  1  synchronous, active-high reset.
- ENA  in  1  port A access enable.
- WEA  in  NUM_BYTES  port A byte write enables.
- ADDRA  in  ADDR_WIDTH  port A address.
- DIA  in  DATA_WIDTH  port A write data.
- DOA  out  DATA_WIDTH  port A read data.
- DOA_VALID  out  1  DOA carries the result of an accepted access.
- ENB, WEB, ADDRB, DIB, DOB, DOB_VALID: same as the port A signals, for port B.
- INIT_BUSY  out  1  high while in reset or clearing; all port accesses are ignored.
- COLLISION  out  1  one-cycle pulse flagging a cross-port address conflict.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high. No other clock or reset domains.
- Reset values, applied on any cycle with RST=1: DOA=DOB=0; DOA_VALID=DOB_VALID=0; COLLISION=0; INIT_BUSY=1; clear pointer=0; pipeline valids flushed.
- RST asserted mid-sweep or mid-read restarts from this state. RAM contents are not otherwise altered by RST.
- Sequencer states:
  - RESET: while RST=1.
  - CLEAR: entered on the first cycle with RST=0 if CLEAR_ON_RESET=1; otherwise go straight to READY. Each cycle writes INIT_VALUE to RAM[ptr] and increments ptr. When ptr = MEMSIZE-1 is written, go to READY. CLEAR lasts exactly MEMSIZE cycles.
  - READY: INIT_BUSY=0; ports operational.
- INIT_BUSY=1 in RESET and CLEAR; ENx, WEx and read requests are ignored; no valid strobes.
- Access acceptance: an access is accepted when ENx=1 in READY.
  - Any set bit of WEx writes the corresponding bytes of DIx into RAM[ADDRx]; unset lanes are preserved.
  - Every accepted access (write or not) also performs a read.
- Read latency:
  - PIPELINED=0: DOx and DOx_VALID update on the edge after acceptance (latency 1).
  - PIPELINED=1: they update one edge later (latency 2).
  - DOx_VALID is a single-cycle pulse per accepted access; back-to-back accesses give back-to-back pulses.
  - DOx holds its last value when no new data arrives.
- Same-port read-during-write:
  - WRITE_MODE=0: returns the pre-write word.
  - WRITE_MODE=1: returns the merged word (new enabled bytes, old others).
- Cross-port, same cycle, same address, both accepted:
  - A reader always sees the pre-write data of the other port's write.
  - Both ports writing: for lanes enabled on both, port B wins; other lanes merge from whichever port enabled them.
  - COLLISION pulses on the next cycle if at least one port wrote. Two reads do not raise COLLISION.
- Addresses ≥ MEMSIZE: writes are dropped; reads return INIT_VALUE; no error flag.
- COLLISION latency is 1 regardless of PIPELINED.

Test Plan:
- Defaults, RST high 3 cycles then low → INIT_BUSY high for exactly 16 cycles after deassert. Read all 16 addresses → every DOA = 0; DOA_VALID pulses 1 cycle after each ENA.
- Port A write 0xAABBCCDD @5 (WEA=4'hF), then write 0x11223344 @5 with WEA=4'b0101 → read @5 returns 0xAA22CC44.
- WRITE_MODE=0 vs 1: RAM@3=0x0; same-cycle ENA, WEA=F, DIA=0x12345678 @3 → DOA=0x00000000 (mode 0) / 0x12345678 (mode 1) next cycle.
- Both ports write @7 in the same cycle: A=0xFFFFFFFF with WEA=F, B=0x00000000 with WEB=4'b0011 → COLLISION=1 for 1 cycle; read @7 = 0xFFFF0000. Same-cycle reads @7 on both ports → COLLISION stays 0.
- PIPELINED=1, ENB on 4 consecutive cycles to addresses 0..3 holding 10,11,12,13 → DOB_VALID high cycles 2..5 after the first request, with DOB=10,11,12,13 in order.
- RST asserted at clear pointer=8, then released → sweep restarts at 0 (INIT_BUSY high 16 full cycles); ENA during the sweep is ignored (no DOA_VALID, no write).
